// File: rtl/seg7_capture.sv
// seg7_capture: samples a multiplexed, active-low 7-segment display bus and
// recovers the four displayed digit codes plus decimal points.
// Optional feature macro: SEG7_CAPTURE_ERR_EN (illegal patterns store code E
// and pulse err); when undefined, illegal patterns are ignored and err is 0.
module seg7_capture #(
  parameter int unsigned SETTLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [7:0] seg,
  output logic [3:0] dout0,
  output logic [3:0] dout1,
  output logic [3:0] dout2,
  output logic [3:0] dout3,
  output logic [3:0] dp,
  output logic       frame_pulse,
  output logic       valid,
  output logic       err
);

  // Count value seen just before the accepting edge (counter then reaches SETTLE-1)
  localparam logic [15:0] ACC_CNT = 16'(SETTLE - 2);

  logic [3:0]  r_an_s1, r_an_s2;
  logic [7:0]  r_seg_s1, r_seg_s2;
  logic [11:0] r_prev;
  logic [15:0] r_cnt;
  logic        r_captured;
  logic [3:0]  r_seen;
  logic [3:0]  r_dout [4];
  logic [3:0]  r_dp;
  logic        r_frame;
  logic        r_valid;

  logic [11:0] w_sync;
  logic        w_change;
  logic        w_onehot;
  logic [1:0]  w_idx;
  logic [3:0]  w_sel;
  logic [3:0]  w_seen_set;
  logic [3:0]  w_code;
  logic        w_legal;
  logic        w_accept;

  assign w_sync     = {r_an_s2, r_seg_s2};
  assign w_change   = (w_sync != r_prev);
  assign w_sel      = ~r_an_s2;
  assign w_seen_set = r_seen | w_sel;
  assign w_accept   = !w_change && (r_cnt == ACC_CNT) && !r_captured && w_onehot;

  // Identify which single digit (if any) the synchronized anodes select
  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_an_s2)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  // Map the active-low segment pattern {g..a} onto a digit code
  always_comb begin
    w_legal = 1'b1;
    w_code  = 4'h0;
    case (r_seg_s2[6:0])
      7'b1000000: w_code = 4'h0;
      7'b1111001: w_code = 4'h1;
      7'b0100100: w_code = 4'h2;
      7'b0110000: w_code = 4'h3;
      7'b0011001: w_code = 4'h4;
      7'b0010010: w_code = 4'h5;
      7'b0000010: w_code = 4'h6;
      7'b1111000: w_code = 4'h7;
      7'b0000000: w_code = 4'h8;
      7'b0010000: w_code = 4'h9;
      7'b0111111: w_code = 4'hA;
      7'b1111111: w_code = 4'hF;
      default:    w_legal = 1'b0;
    endcase
  end

  // Synchronizer, stability counter, digit capture and frame tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an_s1    <= 4'hF;
      r_an_s2    <= 4'hF;
      r_seg_s1   <= 8'hFF;
      r_seg_s2   <= 8'hFF;
      r_prev     <= 12'hFFF;
      r_cnt      <= 16'd0;
      r_captured <= 1'b0;
      r_seen     <= 4'h0;
      r_dp       <= 4'h0;
      r_frame    <= 1'b0;
      r_valid    <= 1'b0;
      for (int k = 0; k < 4; k++) r_dout[k] <= 4'h0;
    end else begin
      r_an_s1  <= an;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
      r_prev   <= w_sync;
      r_frame  <= 1'b0;

      if (w_change)                r_cnt <= 16'd0;
      else if (r_cnt != 16'hFFFF)  r_cnt <= r_cnt + 16'd1;

      if (w_change)      r_captured <= 1'b0;
      else if (w_accept) r_captured <= 1'b1;

`ifdef SEG7_CAPTURE_ERR_EN
      if (w_accept) begin
        r_dout[w_idx] <= w_legal ? w_code : 4'hE;
        r_dp[w_idx]   <= ~r_seg_s2[7];
        if (w_seen_set == 4'hF) begin
          r_seen  <= 4'h0;
          r_frame <= 1'b1;
          r_valid <= 1'b1;
        end else begin
          r_seen  <= w_seen_set;
        end
      end
`else
      if (w_accept && w_legal) begin
        r_dout[w_idx] <= w_code;
        r_dp[w_idx]   <= ~r_seg_s2[7];
        if (w_seen_set == 4'hF) begin
          r_seen  <= 4'h0;
          r_frame <= 1'b1;
          r_valid <= 1'b1;
        end else begin
          r_seen  <= w_seen_set;
        end
      end
`endif
    end
  end

`ifdef SEG7_CAPTURE_ERR_EN
  logic r_err;

  // One-cycle strobe when an illegal pattern is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_accept && !w_legal;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign dout0       = r_dout[0];
  assign dout1       = r_dout[1];
  assign dout2       = r_dout[2];
  assign dout3       = r_dout[3];
  assign dp          = r_dp;
  assign frame_pulse = r_frame;
  assign valid       = r_valid;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture (SETTLE=16), default or ERR_EN build.
module tb_seg7_capture;

  logic       clk;
  logic       rst;
  logic [3:0] an;
  logic [7:0] seg;
  logic [3:0] dout0, dout1, dout2, dout3, dp;
  logic       frame_pulse, valid, err;

  int errors = 0;
  int checks = 0;
  int fp_cnt = 0;
  int err_cnt = 0;

  seg7_capture #(.SETTLE(16)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .dp(dp), .frame_pulse(frame_pulse), .valid(valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes on every rising edge
  always @(posedge clk) begin
    if (frame_pulse === 1'b1) fp_cnt <= fp_cnt + 1;
    if (err === 1'b1)         err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    cycles(n);
  endtask

  function automatic logic [31:0] douts();
    return {16'h0, dout3, dout2, dout1, dout0};
  endfunction

  int fp_before;
  int err_before;

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = 8'hFF;
    cycles(3);
    check("reset_douts", douts(), 32'h0);
    check("reset_dp", 32'(dp), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame", 32'(frame_pulse), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    rst = 1'b0;
    cycles(2);

    // Rotation: digits 1,2,3,0 with dp dark
    drive(4'b1110, 8'hF9, 100);
    drive(4'b1101, 8'hA4, 100);
    drive(4'b1011, 8'hB0, 100);
    check("rot_no_frame_yet", 32'(fp_cnt), 32'd0);
    check("rot_valid_low", 32'(valid), 32'h0);
    drive(4'b0111, 8'hC0, 100);
    check("rot_douts", douts(), 32'h0321);
    check("rot_dp", 32'(dp), 32'h0);
    check("rot_one_frame", 32'(fp_cnt), 32'd1);
    check("rot_valid", 32'(valid), 32'h1);

    // Glitch of 10 cycles must not be accepted
    drive(4'b1110, 8'hC0, 40);
    check("glitch_pre_dout0", 32'(dout0), 32'h0);
    drive(4'b1110, 8'h99, 10);
    drive(4'b1110, 8'hC0, 40);
    check("glitch_dout0", 32'(dout0), 32'h0);

    // Exact acceptance latency of 18 edges, dp lit
    an  = 4'b1101;
    seg = 8'h79;
    cycles(17);
    check("lat_edge17_dout1", 32'(dout1), 32'h2);
    cycles(1);
    check("lat_edge18_dout1", 32'(dout1), 32'h1);
    cycles(22);
    check("lat_dp", 32'(dp), 32'h2);

    // Illegal pattern on digit 2
    err_before = err_cnt;
    drive(4'b1011, 8'hFE, 40);
`ifdef SEG7_CAPTURE_ERR_EN
    check("illegal_dout2", 32'(dout2), 32'hE);
    check("illegal_err", 32'(err_cnt - err_before), 32'd1);
`else
    check("illegal_dout2", 32'(dout2), 32'h3);
    check("illegal_err", 32'(err_cnt - err_before), 32'd0);
`endif

    // Non one-hot anodes are never accepted
    fp_before = fp_cnt;
    drive(4'b1111, 8'hC0, 200);
    drive(4'b1100, 8'hC0, 200);
`ifdef SEG7_CAPTURE_ERR_EN
    check("nonhot_douts", douts(), 32'h0E10);
`else
    check("nonhot_douts", douts(), 32'h0310);
`endif
    check("nonhot_dp", 32'(dp), 32'h2);
    check("nonhot_frame", 32'(fp_cnt - fp_before), 32'd0);

    // Third digit captured, then reset mid-frame
    drive(4'b1011, 8'hB0, 40);
    check("pre_rst_no_frame", 32'(fp_cnt - fp_before), 32'd0);
    check("pre_rst_dout2", 32'(dout2), 32'h3);
    rst = 1'b1;
    #2;
    check("mid_rst_douts", douts(), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_dp", 32'(dp), 32'h0);
    cycles(3);
    rst = 1'b0;
    cycles(1);

    fp_before = fp_cnt;
    drive(4'b0111, 8'hF9, 40);
    check("post_rst_dout3", 32'(dout3), 32'h1);
    check("post_rst_no_frame", 32'(fp_cnt - fp_before), 32'd0);
    check("post_rst_valid", 32'(valid), 32'h0);
    drive(4'b1110, 8'hA4, 40);
    drive(4'b1101, 8'hB0, 40);
    check("post_rst_three_no_frame", 32'(fp_cnt - fp_before), 32'd0);
    drive(4'b1011, 8'h40, 40);
    check("post_rst_frame", 32'(fp_cnt - fp_before), 32'd1);
    check("post_rst_valid_set", 32'(valid), 32'h1);
    check("post_rst_douts", douts(), 32'h1032);
    check("post_rst_dp", 32'(dp), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter: SETTLE, default 16, consecutive stable synchronized cycles required before a digit is accepted; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 an  input  4  digit anode strobes, active-low; bit k low selects digit k.
REQ-005 seg  input  8  segment lines, active-low, {dp,g,f,e,d,c,b,a}.
REQ-006 dout0..dout3  output  4 each  decoded code of digits 0..3.
REQ-007 dp  output  4  decimal point state per digit; 1 = lit.
REQ-008 frame_pulse  output  1  one-cycle strobe when all four digits have been captured since the last strobe.
REQ-009 valid  output  1  high once at least one complete frame has been captured.
REQ-010 err  output  1  one-cycle strobe on an unrecognised segment pattern.

Function
REQ-011 an and seg shall pass through a 2-flop synchronizer; all later logic uses the synchronized values only.
REQ-012 A 16-bit stability counter shall clear on any change of synchronized {an,seg}, increment otherwise, and saturate at 65535.
REQ-013 Acceptance shall occur on the edge where the counter reaches SETTLE-1, so the registered outputs update 2+SETTLE edges after a clean input change.
REQ-014 Acceptance requires synchronized an to be exactly one-hot-low (1110, 1101, 1011, 0111); any other an value is never accepted.
REQ-015 At most one acceptance per stable interval; a captured flag set on acceptance clears on the next change of synchronized {an,seg}.
REQ-016 Decode of seg[6:0]: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0111111->A (dash), 1111111->F (blank); all else illegal.
REQ-017 On acceptance of digit k with a legal pattern: doutk <= code, dp[k] <= ~seg[7], seen[k] <= 1.
REQ-018 When seen becomes 1111, the same edge shall clear seen, assert frame_pulse for one cycle and set valid; valid stays high until reset.
REQ-019 Re-capture of an already-seen digit before the frame completes shall overwrite doutk/dp[k] without affecting seen.
REQ-020 Outputs not being updated shall hold their values between acceptances.

Reset
REQ-021 rst high shall asynchronously force: dout0..3=0, dp=0, valid=0, frame_pulse=0, err=0, synchronizer stages=all ones, counter=0, seen=0, captured=0.
REQ-022 Reset asserted mid-frame discards partial frames; capture restarts from seen=0 after release.

Configuration
REQ-023 Macro SEG7_CAPTURE_ERR_EN defined: an illegal pattern at acceptance sets doutk=E, dp[k] per seg[7], seen[k]=1, and pulses err for one cycle.
REQ-024 SEG7_CAPTURE_ERR_EN undefined: err tied 0; illegal patterns are ignored (no output change, seen unchanged, captured still set).

Verification (SETTLE=16)
REQ-025 Rotate an 1110/1101/1011/0111 with seg F9/A4/B0/C0, 100 cycles each -> dout0..3=1,2,3,0, dp=0000, one frame_pulse on digit-3 capture, valid=1 thereafter.
REQ-026 Hold an=1110 seg=C0 stable, then change seg to 99 for 10 cycles only, then back to C0 -> no acceptance of 4; dout0 stays 0.
REQ-027 an=1101 seg=79 held 40 cycles -> dout1=1, dp[1]=1, dout1 updates exactly 18 edges after the input change.
REQ-028 an=1011 seg=FE held 40 cycles -> with macro dout2=E and one err pulse; without macro dout2 unchanged, err=0.
REQ-029 an=1111 or 1100 with seg=C0 held 200 cycles -> no output change, seen unchanged.
REQ-030 Assert rst after three digits captured, release, supply one digit -> all outputs 0 during reset; no frame_pulse until all four digits are captured again.
